// File: rtl/rv_ctl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit and its datapath:
// FSM state type, opcodes, datapath select encodings and ALU operations.
package rv_ctl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_WB_ALU    = 4'd4,
        S_MEM_ADDR  = 4'd5,
        S_MEM_RD    = 4'd6,
        S_MEM_WR    = 4'd7,
        S_WB_MEM    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR_CALC = 4'd11,
        S_JALR_WB   = 4'd12,
        S_HALT      = 4'd13
    } state_t;

    // Opcodes
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // PC source
    localparam logic PC_PLUS4 = 1'b0;
    localparam logic PC_ALU   = 1'b1;

    // Register write-back source
    localparam logic [1:0] WB_MDR    = 2'd0;
    localparam logic [1:0] WB_ALUOUT = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    // Immediate format
    localparam logic [1:0] IMM_J = 2'd0;
    localparam logic [1:0] IMM_B = 2'd1;
    localparam logic [1:0] IMM_S = 2'd2;
    localparam logic [1:0] IMM_L = 2'd3;

    // ALU operand selects
    localparam logic [1:0] ALUA_PCC = 2'd0;
    localparam logic [1:0] ALUA_REG = 2'd1;
    localparam logic [1:0] ALUB_REG = 2'd0;
    localparam logic [1:0] ALUB_IMM = 2'd1;

    // ALU operations
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // Branch funct3 codes
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // State that follows DECODE for a given opcode; unknown opcodes halt.
    function automatic state_t decode_next(input logic [6:0] opcode);
        state_t nxt;
        case (opcode)
            OP_RTYPE:           nxt = S_EXEC_R;
            OP_ITYPE:           nxt = S_EXEC_I;
            OP_LOAD, OP_STORE:  nxt = S_MEM_ADDR;
            OP_BRANCH:          nxt = S_BRANCH;
            OP_JAL:             nxt = S_JAL;
            OP_JALR:            nxt = S_JALR_CALC;
            default:            nxt = S_HALT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rv_ctl_alu_dec.sv
// ALU operation decoder: funct3/funct7[5] to ALU_* code. funct7[5] selects
// SUB only for R-type; it always selects SRA over SRL.
module rv_alu_dec
    import rv_ctl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       is_rtype,
    output logic [3:0] alusel
);

    // Map funct3 (plus the alternate-op bit) onto an ALU operation
    always_comb begin
        alusel = ALU_ADD;
        case (funct3)
            3'b000:  alusel = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  alusel = ALU_SLL;
            3'b010:  alusel = ALU_SLT;
            3'b011:  alusel = ALU_SLTU;
            3'b100:  alusel = ALU_XOR;
            3'b101:  alusel = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  alusel = ALU_OR;
            3'b111:  alusel = ALU_AND;
            default: alusel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv_ctl.sv
// Multicycle control unit: Moore FSM driving the datapath selects/enables
// and the data-memory request/ready handshake.
// Optional feature macro: RV_CTL_BRANCH_EXT_EN adds BLT/BGE/BLTU/BGEU.
module rv_ctl
    import rv_ctl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        dmem_ready,
    output logic        pcsourse,
    output logic        pcwrite,
    output logic        pccen,
    output logic        irwrite,
    output logic        regwen,
    output logic        mdrwrite,
    output logic [1:0]  wbsel,
    output logic [1:0]  immsel,
    output logic [1:0]  asel,
    output logic [1:0]  bsel,
    output logic [3:0]  alusel,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        retire,
    output logic        illegal
);

    state_t      state;
    state_t      next_state;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        is_rtype;
    logic [3:0]  dec_alusel;

    logic        br_valid;
    logic        br_taken;
    logic [3:0]  br_alusel;

    // Raw decode before the reset gate
    logic        pcwrite_raw;
    logic        pccen_raw;
    logic        irwrite_raw;
    logic        regwen_raw;
    logic        mdrwrite_raw;
    logic        dmem_req_raw;
    logic        dmem_we_raw;
    logic        retire_raw;
    logic        illegal_raw;

    logic        unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7_5     = instr[30];
    assign is_rtype     = (state == S_EXEC_R);
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    rv_alu_dec u_alu_dec (
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .is_rtype (is_rtype),
        .alusel   (dec_alusel)
    );

    // Branch condition decode: ALU compare op and taken decision from zero
    always_comb begin
        br_valid  = 1'b0;
        br_taken  = 1'b0;
        br_alusel = ALU_SUB;
        case (funct3)
            F3_BEQ: begin
                br_valid = 1'b1;
                br_taken = zero;
            end
            F3_BNE: begin
                br_valid = 1'b1;
                br_taken = ~zero;
            end
`ifdef RV_CTL_BRANCH_EXT_EN
            F3_BLT: begin
                br_valid  = 1'b1;
                br_alusel = ALU_SLT;
                br_taken  = ~zero;
            end
            F3_BGE: begin
                br_valid  = 1'b1;
                br_alusel = ALU_SLT;
                br_taken  = zero;
            end
            F3_BLTU: begin
                br_valid  = 1'b1;
                br_alusel = ALU_SLTU;
                br_taken  = ~zero;
            end
            F3_BGEU: begin
                br_valid  = 1'b1;
                br_alusel = ALU_SLTU;
                br_taken  = zero;
            end
`endif
            default: begin
                br_valid = 1'b0;
                br_taken = 1'b0;
            end
        endcase
    end

    // State register; reset parks the FSM in FETCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-state output decode
    always_comb begin
        next_state   = state;
        pcsourse     = PC_PLUS4;
        pcwrite_raw  = 1'b0;
        pccen_raw    = 1'b0;
        irwrite_raw  = 1'b0;
        regwen_raw   = 1'b0;
        mdrwrite_raw = 1'b0;
        dmem_req_raw = 1'b0;
        dmem_we_raw  = 1'b0;
        retire_raw   = 1'b0;
        illegal_raw  = 1'b0;
        wbsel        = WB_ALUOUT;
        immsel       = IMM_B;
        asel         = ALUA_PCC;
        bsel         = ALUB_REG;
        alusel       = ALU_ADD;
        case (state)
            S_FETCH: begin
                irwrite_raw = 1'b1;
                pccen_raw   = 1'b1;
                pcwrite_raw = 1'b1;
                pcsourse    = PC_PLUS4;
                next_state  = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch/jump target into aluout
                asel       = ALUA_PCC;
                bsel       = ALUB_IMM;
                alusel     = ALU_ADD;
                immsel     = (opcode == OP_JAL) ? IMM_J : IMM_B;
                next_state = decode_next(opcode);
            end
            S_EXEC_R: begin
                asel       = ALUA_REG;
                bsel       = ALUB_REG;
                alusel     = dec_alusel;
                next_state = S_WB_ALU;
            end
            S_EXEC_I: begin
                asel       = ALUA_REG;
                bsel       = ALUB_IMM;
                immsel     = IMM_L;
                alusel     = dec_alusel;
                next_state = S_WB_ALU;
            end
            S_WB_ALU: begin
                regwen_raw = 1'b1;
                wbsel      = WB_ALUOUT;
                retire_raw = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_ADDR: begin
                asel       = ALUA_REG;
                bsel       = ALUB_IMM;
                alusel     = ALU_ADD;
                immsel     = (opcode == OP_STORE) ? IMM_S : IMM_L;
                next_state = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                // Address selects repeated so aluout stays stable
                asel         = ALUA_REG;
                bsel         = ALUB_IMM;
                alusel       = ALU_ADD;
                immsel       = IMM_L;
                dmem_req_raw = 1'b1;
                mdrwrite_raw = dmem_ready;
                if (dmem_ready) begin
                    next_state = S_WB_MEM;
                end else begin
                    next_state = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                asel         = ALUA_REG;
                bsel         = ALUB_IMM;
                alusel       = ALU_ADD;
                immsel       = IMM_S;
                dmem_req_raw = 1'b1;
                dmem_we_raw  = 1'b1;
                if (dmem_ready) begin
                    retire_raw = 1'b1;
                    next_state = S_FETCH;
                end else begin
                    next_state = S_MEM_WR;
                end
            end
            S_WB_MEM: begin
                regwen_raw = 1'b1;
                wbsel      = WB_MDR;
                retire_raw = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                asel   = ALUA_REG;
                bsel   = ALUB_REG;
                alusel = br_alusel;
                if (br_valid) begin
                    retire_raw = 1'b1;
                    next_state = S_FETCH;
                    if (br_taken) begin
                        pcwrite_raw = 1'b1;
                        pcsourse    = PC_ALU;
                    end else begin
                        pcwrite_raw = 1'b0;
                    end
                end else begin
                    next_state = S_HALT;
                end
            end
            S_JAL: begin
                regwen_raw  = 1'b1;
                wbsel       = WB_PC;
                pcwrite_raw = 1'b1;
                pcsourse    = PC_ALU;
                retire_raw  = 1'b1;
                next_state  = S_FETCH;
            end
            S_JALR_CALC: begin
                asel       = ALUA_REG;
                bsel       = ALUB_IMM;
                immsel     = IMM_L;
                alusel     = ALU_ADD;
                next_state = S_JALR_WB;
            end
            S_JALR_WB: begin
                regwen_raw  = 1'b1;
                wbsel       = WB_PC;
                pcwrite_raw = 1'b1;
                pcsourse    = PC_ALU;
                retire_raw  = 1'b1;
                next_state  = S_FETCH;
            end
            S_HALT: begin
                illegal_raw = 1'b1;
                next_state  = S_HALT;
            end
            default: begin
                next_state = S_HALT;
            end
        endcase
    end

    // While rst is high every enable, request, retire and illegal is held low
    assign pcwrite  = pcwrite_raw  & ~rst;
    assign pccen    = pccen_raw    & ~rst;
    assign irwrite  = irwrite_raw  & ~rst;
    assign regwen   = regwen_raw   & ~rst;
    assign mdrwrite = mdrwrite_raw & ~rst;
    assign dmem_req = dmem_req_raw & ~rst;
    assign dmem_we  = dmem_we_raw  & ~rst;
    assign retire   = retire_raw   & ~rst;
    assign illegal  = illegal_raw  & ~rst;

endmodule

// File: tb/tb_rv_ctl.sv
// Bench for rv_ctl: a small behavioural datapath runs a directed program;
// per-instruction expectations are queued up front and a monitor checks
// them at each retire pulse.
module tb_rv_ctl;
    import rv_ctl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr;
    logic        zero;
    logic        dmem_ready = 1'b0;
    logic        pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite;
    logic [1:0]  wbsel, immsel, asel, bsel;
    logic [3:0]  alusel;
    logic        dmem_req, dmem_we, retire, illegal;

    rv_ctl dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .dmem_ready(dmem_ready),
        .pcsourse(pcsourse), .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite),
        .regwen(regwen), .mdrwrite(mdrwrite), .wbsel(wbsel), .immsel(immsel),
        .asel(asel), .bsel(bsel), .alusel(alusel), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .retire(retire), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural datapath ----------------
    logic [31:0] regs [32];
    logic [31:0] imem [128];
    logic [31:0] dmem [64];
    logic [31:0] pc, pcc, ir, aluout, mdr, reset_pc;
    logic [31:0] imm, opa, opb, alu_res, wbval;
    logic        hold_mem = 1'b0;

    assign instr = ir;
    assign zero  = (alu_res == 32'd0);

    always_comb begin
        imm = 32'd0;
        case (immsel)
            IMM_L:   imm = {{20{ir[31]}}, ir[31:20]};
            IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            default: imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        endcase
        opa = (asel == ALUA_PCC) ? pcc : regs[ir[19:15]];
        opb = (bsel == ALUB_IMM) ? imm : regs[ir[24:20]];
        alu_res = 32'd0;
        case (alusel)
            ALU_ADD:  alu_res = opa + opb;
            ALU_SUB:  alu_res = opa - opb;
            ALU_SLL:  alu_res = opa << opb[4:0];
            ALU_SLT:  alu_res = {31'd0, $signed(opa) < $signed(opb)};
            ALU_SLTU: alu_res = {31'd0, opa < opb};
            ALU_XOR:  alu_res = opa ^ opb;
            ALU_SRL:  alu_res = opa >> opb[4:0];
            ALU_SRA:  alu_res = $signed(opa) >>> opb[4:0];
            ALU_OR:   alu_res = opa | opb;
            ALU_AND:  alu_res = opa & opb;
            default:  alu_res = 32'd0;
        endcase
    end

    // Control snapshot taken mid-cycle, applied at the next rising edge
    logic        s_pcwrite, s_pcsourse, s_pccen, s_irwrite, s_regwen, s_mdrwrite;
    logic        s_req, s_we, s_ready;
    logic [1:0]  s_wbsel;
    logic [31:0] s_alu;

    always_comb begin
        case (s_wbsel)
            WB_MDR:  wbval = mdr;
            WB_PC:   wbval = pc;
            default: wbval = aluout;
        endcase
    end

    // Datapath registers updated from the snapshot of the control outputs
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= reset_pc;
        end else begin
            if (s_irwrite) ir <= imem[pc[8:2]];
            if (s_pccen) pcc <= pc;
            if (s_pcwrite) pc <= (s_pcsourse == PC_ALU) ? aluout : pc + 32'd4;
            aluout <= s_alu;
            if (s_mdrwrite) mdr <= dmem[aluout[7:2]];
            if (s_req && s_we && s_ready) dmem[aluout[7:2]] <= regs[ir[24:20]];
            if (s_regwen && ir[11:7] != 5'd0) regs[ir[11:7]] <= wbval;
        end
    end

    // Memory responder: ready after a per-access wait; stray ready when idle
    int req_cnt = 0;
    initial begin
        forever begin
            int w;
            @(posedge clk);
            #1;
            w = (pcc == 32'h4) ? 2 : 0;
            if (hold_mem) w = 1000000;
            if (dmem_req) begin
                dmem_ready = (req_cnt >= w);
                req_cnt++;
            end else begin
                dmem_ready = 1'b1;
                req_cnt = 0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int         cyc;
        int         req;
        int         mdr;
        int         tk;
        logic       rw;
        logic [1:0] wb;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;
    int   cyc = 0, reqc = 0, mdrc = 0, tkc = 0, n_ret = 0;

    task automatic push(input int c, input int r, input int m, input int t,
                        input logic rw, input logic [1:0] wb);
        exp_t x;
        x.cyc = c; x.req = r; x.mdr = m; x.tk = t; x.rw = rw; x.wb = wb;
        exp_q.push_back(x);
    endtask

    // Monitor: snapshot controls, count per-instruction events, check at retire
    always @(negedge clk) begin
        s_pcwrite = pcwrite; s_pcsourse = pcsourse; s_pccen = pccen;
        s_irwrite = irwrite; s_regwen = regwen; s_mdrwrite = mdrwrite;
        s_req = dmem_req; s_we = dmem_we; s_ready = dmem_ready;
        s_wbsel = wbsel; s_alu = alu_res;
        if (rst) begin
            cyc = 0; reqc = 0; mdrc = 0; tkc = 0;
        end else begin
            if (irwrite) begin
                cyc = 1; reqc = 0; mdrc = 0; tkc = 0;
            end else begin
                cyc++;
            end
            if (dmem_req) reqc++;
            if (mdrwrite) mdrc++;
            if (pcwrite && pcsourse == PC_ALU) tkc++;
            if (retire) begin
                n_ret++;
                if (exp_q.size() == 0) begin
                    chk("unexpected retire", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("i%0d cycles", n_ret), cyc, e.cyc);
                    chk($sformatf("i%0d req cycles", n_ret), reqc, e.req);
                    chk($sformatf("i%0d mdrwrite cycles", n_ret), mdrc, e.mdr);
                    chk($sformatf("i%0d pc_alu writes", n_ret), tkc, e.tk);
                    chk($sformatf("i%0d regwen", n_ret), {31'd0, regwen}, {31'd0, e.rw});
                    if (e.rw) chk($sformatf("i%0d wbsel", n_ret), {30'd0, wbsel}, {30'd0, e.wb});
                    chk($sformatf("i%0d illegal", n_ret), {31'd0, illegal}, 32'd0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int   ret_before;
        logic seen;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        for (int i = 0; i < 128; i++) imem[i] = 32'h0000007F;
        for (int i = 0; i < 64; i++) dmem[i] = 32'd0;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        dmem[0] = 32'hDEADBEEF;
        ir = 32'd0; pcc = 32'd0; aluout = 32'd0; mdr = 32'd0;
        imem[0]  = 32'h002081B3;  // add  x3, x1, x2
        imem[1]  = 32'h00002203;  // lw   x4, 0(x0)    (2 wait cycles)
        imem[2]  = 32'h00302423;  // sw   x3, 8(x0)
        imem[3]  = 32'h00108463;  // beq  x1, x1, +8   taken -> 0x14
        imem[5]  = 32'h00208463;  // beq  x1, x2, +8   not taken
        imem[6]  = 32'h10000367;  // jalr x6, 0x100(x0)
        imem[64] = 32'h010000EF;  // jal  x1, +16 at 0x100
        imem[68] = 32'h40008393;  // addi x7, x1, 0x400 (bit 30 set)
        imem[69] = 32'h40238433;  // sub  x8, x7, x2
        imem[70] = 32'h0000007F;  // illegal opcode
        reset_pc = 32'd0;

        push(4, 0, 0, 0, 1'b1, WB_ALUOUT);  // add
        push(7, 3, 1, 0, 1'b1, WB_MDR);     // lw
        push(4, 1, 0, 0, 1'b0, WB_MDR);     // sw
        push(3, 0, 0, 1, 1'b0, WB_MDR);     // beq taken
        push(3, 0, 0, 0, 1'b0, WB_MDR);     // beq not taken
        push(4, 0, 0, 1, 1'b1, WB_PC);      // jalr
        push(3, 0, 0, 1, 1'b1, WB_PC);      // jal
        push(4, 0, 0, 0, 1'b1, WB_ALUOUT);  // addi
        push(4, 0, 0, 0, 1'b1, WB_ALUOUT);  // sub

        repeat (3) @(posedge clk);
        #1;
        chk("reset irwrite", {31'd0, irwrite}, 32'd0);
        chk("reset pcwrite", {31'd0, pcwrite}, 32'd0);
        chk("reset dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("reset illegal", {31'd0, illegal}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        for (int i = 0; i < 300 && !illegal; i++) @(negedge clk);
        chk("halt illegal", {31'd0, illegal}, 32'd1);
        chk("all retired", exp_q.size(), 32'd0);
        chk("x3 add", regs[3], 32'd12);
        chk("x4 load", regs[4], 32'hDEADBEEF);
        chk("store data", dmem[2], 32'd12);
        chk("x6 jalr link", regs[6], 32'h1C);
        chk("x1 jal link", regs[1], 32'h104);
        chk("x7 addi", regs[7], 32'h504);
        chk("x8 sub", regs[8], 32'h4FD);
        chk("pc at halt", pc, 32'h11C);

        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (irwrite) seen = 1'b1;
        end
        chk("halt no irwrite", {31'd0, seen}, 32'd0);
        chk("halt sticky", {31'd0, illegal}, 32'd1);

        // Reset out of HALT, restart at the store with memory never ready
        ret_before = n_ret;
        reset_pc = 32'h8;
        hold_mem = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("rst clears illegal", {31'd0, illegal}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("restart fetch", {31'd0, irwrite}, 32'd1);
        for (int i = 0; i < 20 && !dmem_req; i++) @(negedge clk);
        chk("sw request", {31'd0, dmem_req}, 32'd1);
        chk("sw we", {31'd0, dmem_we}, 32'd1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst drops req", {31'd0, dmem_req}, 32'd0);
        chk("rst no retire", {31'd0, retire}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("fetch after rst", {31'd0, irwrite}, 32'd1);
        chk("no retire in aborted sw", n_ret, ret_before);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
